// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source side of a two-phase (toggle) req/ack clock-domain-crossing channel.
//   A word accepted on din/din_valid/din_ready is held stable on tx_data, and
//   tx_req toggles once to announce it. The far side answers by toggling
//   rx_ack. That ack passes through a SYNC_STAGES flop synchronizer before the
//   FSM compares it against tx_req. Two sticky error flags are provided: ack
//   timeout and a spurious ack toggle seen while idle.
//
// Ports
//   Aclk          in   sole clock, rising edge
//   reset         in   asynchronous, active-high, clears all state
//   din           in   word to send (WIDTH bits)
//   din_valid     in   din is valid
//   din_ready     out  block can accept (IDLE and not in reset)
//   tx_data       out  registered word to the far domain, stable while busy
//   tx_req        out  registered request toggle to the far domain
//   rx_ack        in   asynchronous ack toggle from the far domain
//   busy          out  transfer outstanding (WAIT_ACK)
//   done          out  one-cycle pulse on transfer completion
//   timeout_err   out  sticky: no ack within TIMEOUT cycles (0 disables)
//   protocol_err  out  sticky: synchronized ack changed while idle
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic             Aclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             rx_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             protocol_err
);

  // The counter must be able to hold TIMEOUT itself, which is its saturation value.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_req_q, tx_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             protocol_err_q, protocol_err_d;

  // rx_ack synchronizer: a plain shift chain with no logic between stages.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_ack};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // din_ready depends only on the state register and reset. It has no path
  // from din_valid, so upstream may wait for ready before asserting valid.
  assign din_ready = (state_q == IDLE) && !reset;

  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      tx_data_q      <= '0;
      tx_req_q       <= 1'b0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_data_q      <= tx_data_d;
      tx_req_q       <= tx_req_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tx_data_d      = tx_data_q;
    tx_req_d       = tx_req_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    timeout_err_d  = timeout_err_q;
    protocol_err_d = protocol_err_q;

    case (state_q)
      IDLE: begin
        // When the link is idle the acknowledged level must equal tx_req.
        // Any difference means the far side toggled when it should not have.
        if (ack_s != tx_req_q) begin
          protocol_err_d = 1'b1;
        end
        if (din_valid && din_ready) begin
          tx_data_d = din;
          tx_req_d  = ~tx_req_q;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == tx_req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Only the flag is raised. The toggle is still outstanding, so the
          // FSM keeps waiting and a late ack still completes the transfer.
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data      = tx_data_q;
  assign tx_req       = tx_req_q;
  assign busy         = (state_q == WAIT_ACK);
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;

  logic             Aclk;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_req;
  logic             rx_ack;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             protocol_err;

  // In loopback, rx_ack follows tx_req. Otherwise the bench drives ack_force.
  logic loop_en;
  logic ack_force;
  assign rx_ack = loop_en ? tx_req : ack_force;

  int n_checks = 0;
  int n_bad    = 0;

  cdc_handshake_tx #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(3),
    .TIMEOUT    (8)
  ) dut (
    .Aclk        (Aclk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .protocol_err(protocol_err)
  );

  initial Aclk = 1'b0;
  always #5 Aclk = ~Aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge Aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       exp_req;
    int         n_done;

    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    loop_en   = 1'b1;
    ack_force = 1'b0;
    tick();
    tick();

    // ---- reset values
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_req", 32'(tx_req), 32'h0);
    check("rst_din_ready", 32'(din_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_protocol_err", 32'(protocol_err), 32'h0);
    reset = 1'b0;
    #1;
    check("rel_din_ready", 32'(din_ready), 32'h1);

    // ---- loopback: 0xA5 accepted at edge 0, 0x3C at edge 5
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();                                   // edge 0
    check("lb_tx_data_a5", 32'(tx_data), 32'hA5);
    check("lb_tx_req_1", 32'(tx_req), 32'h1);
    check("lb_busy", 32'(busy), 32'h1);
    check("lb_not_ready", 32'(din_ready), 32'h0);
    din = 8'h3C;                              // valid held high, ignored while busy
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("lb_no_done_e%0d", e), 32'(done), 32'h0);
      check($sformatf("lb_hold_e%0d", e), 32'(tx_data), 32'hA5);
    end
    tick();                                   // edge 4
    check("lb_done_e4", 32'(done), 32'h1);
    check("lb_ready_e4", 32'(din_ready), 32'h1);
    tick();                                   // edge 5: second accept
    check("lb_done_e5", 32'(done), 32'h0);
    check("lb_tx_data_3c", 32'(tx_data), 32'h3C);
    check("lb_tx_req_0", 32'(tx_req), 32'h0);
    din_valid = 1'b0;
    for (int e = 6; e <= 8; e++) tick();
    tick();                                   // edge 9
    check("lb_done_e9", 32'(done), 32'h1);

    // ---- back-to-back stream 0x01..0x10, one accept every 5 edges
    exp_req   = 1'b0;
    n_done    = 0;
    din       = 8'h01;
    din_valid = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      tick();                                 // accept edge
      exp_req = ~exp_req;
      check($sformatf("st_data_%0d", w), 32'(tx_data), 32'(w));
      check($sformatf("st_req_%0d", w), 32'(tx_req), 32'(exp_req));
      din = 8'(w + 1);
      for (int e = 1; e <= 4; e++) begin
        tick();
        if (done) n_done++;
      end
      check($sformatf("st_done_at4_%0d", w), 32'(done), 32'h1);
    end
    din_valid = 1'b0;
    check("st_done_count", 32'(n_done), 32'd16);
    check("st_timeout_err", 32'(timeout_err), 32'h0);
    check("st_protocol_err", 32'(protocol_err), 32'h0);

    // ---- ack withheld: rx_ack stuck at 0 (tx_req is 0 after 16 toggles)
    ack_force = 1'b0;
    loop_en   = 1'b0;
    din       = 8'h77;
    din_valid = 1'b1;
    tick();                                   // edge 0 of WAIT_ACK
    din_valid = 1'b0;
    check("to_tx_req", 32'(tx_req), 32'h1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("to_clear_e%0d", e), 32'(timeout_err), 32'h0);
    end
    tick();                                   // edge 8
    check("to_set_e8", 32'(timeout_err), 32'h1);
    check("to_busy", 32'(busy), 32'h1);
    ack_force = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("to_late_no_done_%0d", e), 32'(done), 32'h0);
    end
    tick();
    check("to_late_done", 32'(done), 32'h1);
    check("to_sticky", 32'(timeout_err), 32'h1);
    check("to_idle", 32'(busy), 32'h0);

    // ---- send 0x5A with ack withheld (ack stays 1, tx_req goes 0)
    din       = 8'h5A;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("bz_tx_data", 32'(tx_data), 32'h5A);
    check("bz_tx_req", 32'(tx_req), 32'h0);
    tick();
    // valid pulsed while busy: must be ignored
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("bz_ignore_data", 32'(tx_data), 32'h5A);
    check("bz_ignore_req", 32'(tx_req), 32'h0);
    check("bz_busy", 32'(busy), 32'h1);

    // ---- asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("ar_tx_req", 32'(tx_req), 32'h0);
    check("ar_tx_data", 32'(tx_data), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    check("ar_timeout_err", 32'(timeout_err), 32'h0);
    check("ar_protocol_err", 32'(protocol_err), 32'h0);
    check("ar_din_ready", 32'(din_ready), 32'h0);
    ack_force = 1'b0;                         // far domain reset as well
    tick();
    reset = 1'b0;
    tick();
    check("ar_rel_ready", 32'(din_ready), 32'h1);
    check("ar_rel_perr", 32'(protocol_err), 32'h0);

    // ---- spurious ack while idle with tx_req=0
    ack_force = 1'b1;
    tick();
    tick();
    ack_force = 1'b0;
    check("sp_not_yet", 32'(protocol_err), 32'h0);
    for (int e = 3; e <= 5; e++) begin
      tick();
      check($sformatf("sp_no_done_e%0d", e), 32'(done), 32'h0);
      check($sformatf("sp_idle_e%0d", e), 32'(busy), 32'h0);
    end
    check("sp_perr_set", 32'(protocol_err), 32'h1);
    check("sp_tx_req", 32'(tx_req), 32'h0);
    tick();
    tick();
    check("sp_perr_sticky", 32'(protocol_err), 32'h1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
